// File: rtl/alu_uart_ctrl_if.sv
// Byte-stream and ALU handshake bundle for the command sequencer.
// The controller uses the slave view; the surrounding fabric (or a bench) uses master.
interface alu_uart_ctrl_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        alu_valid_o;
    logic        alu_ready_i;
    logic [31:0] alu_result_i;
    logic        alu_result_valid_i;
    logic        error_o;

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i, alu_ready_i, alu_result_i, alu_result_valid_i,
        output rx_ready_o, tx_data_o, tx_valid_o, alu_op_o, alu_a_o, alu_b_o, alu_valid_o, error_o
    );

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i, alu_ready_i, alu_result_i, alu_result_valid_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, alu_op_o, alu_a_o, alu_b_o, alu_valid_o, error_o
    );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Command sequencer: parses framed UART packets, echoes payloads or folds
// 32-bit operands through the ALU, and returns result/error bytes.
module alu_uart_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input logic            clk_i,
    input logic            rst_i,
    alu_uart_ctrl_if.slave bus
);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPERAND,
        S_ALU_REQ, S_ALU_WAIT, S_TX_RESULT, S_DRAIN, S_TX_ERR
    } state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_opcode, r_len_lo, r_hold;
    logic [15:0] r_cnt;
    logic [31:0] r_acc, r_opnd, r_tmo;
    logic [1:0]  r_byte_idx;
    logic        r_first, r_hold_full, r_err;

    logic        w_rx_ready, w_tx_valid, w_rx_fire, w_tx_fire, w_tmo_run, w_timeout, w_is_alu;
    logic [15:0] w_len;
    logic [31:0] w_word;
    logic [7:0]  w_tx_data;

    assign w_len    = {bus.rx_data_i, r_len_lo};
    assign w_word   = {bus.rx_data_i, r_opnd[31:8]};
    assign w_is_alu = (r_opcode == 8'hAD) || (r_opcode == 8'h88) || (r_opcode == 8'hD1);

    assign w_rx_ready = (r_state inside {S_IDLE, S_RSV, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN})
                      || (r_state == S_ECHO && !r_hold_full);
    assign w_tx_valid = (r_state == S_ECHO && r_hold_full)
                      || (r_state == S_TX_RESULT) || (r_state == S_TX_ERR);
    assign w_rx_fire  = bus.rx_valid_i && w_rx_ready;
    assign w_tx_fire  = w_tx_valid && bus.tx_ready_i;

    // Inactivity is only meaningful while waiting on the sender.
    assign w_tmo_run = (r_state inside {S_RSV, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN})
                     || (r_state == S_ECHO && !r_hold_full);
    assign w_timeout = w_tmo_run && !w_rx_fire && (r_tmo == TMO_LAST);

    always_comb begin
        w_tx_data = '0;
        case (r_state)
            S_ECHO:      w_tx_data = r_hold;
            S_TX_RESULT: w_tx_data = r_acc[{r_byte_idx, 3'b000} +: 8];
            S_TX_ERR:    w_tx_data = ERR_BYTE;
            default:     w_tx_data = '0;
        endcase
    end

    assign bus.rx_ready_o  = w_rx_ready && !rst_i;
    assign bus.tx_valid_o  = w_tx_valid;
    assign bus.tx_data_o   = w_tx_data;
    assign bus.alu_valid_o = (r_state == S_ALU_REQ);
    assign bus.alu_op_o    = (r_opcode == 8'h88) ? 2'd1 : (r_opcode == 8'hD1) ? 2'd2 : 2'd0;
    assign bus.alu_a_o     = r_acc;
    assign bus.alu_b_o     = r_opnd;
    assign bus.error_o     = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_rx_fire) w_next = S_RSV;
                S_RSV:    if (w_rx_fire) w_next = S_LEN_LO;
                S_LEN_LO: if (w_rx_fire) w_next = S_LEN_HI;
                S_LEN_HI: begin
                    if (w_rx_fire) begin
                        if (r_opcode == 8'hEC && w_len == 16'd4)                    w_next = S_IDLE;
                        else if (r_opcode == 8'hEC && w_len > 16'd4)                w_next = S_ECHO;
                        else if (w_is_alu && w_len >= 16'd8 && w_len[1:0] == 2'b00) w_next = S_OPERAND;
                        else if (w_len <= 16'd4)                                    w_next = S_TX_ERR;
                        else                                                        w_next = S_DRAIN;
                    end
                end
                S_ECHO:    if (w_tx_fire && r_cnt == 16'd1) w_next = S_IDLE;
                S_OPERAND: begin
                    if (w_rx_fire && r_byte_idx == 2'd3) begin
                        if (!r_first)            w_next = S_ALU_REQ;
                        else if (r_cnt == 16'd1) w_next = S_TX_RESULT;
                    end
                end
                S_ALU_REQ:   if (bus.alu_ready_i) w_next = S_ALU_WAIT;
                S_ALU_WAIT:  if (bus.alu_result_valid_i) w_next = (r_cnt == 16'd0) ? S_TX_RESULT : S_OPERAND;
                S_TX_RESULT: if (w_tx_fire && r_byte_idx == 2'd3) w_next = S_IDLE;
                S_DRAIN:     if (w_rx_fire && r_cnt == 16'd1) w_next = S_TX_ERR;
                S_TX_ERR:    if (w_tx_fire) w_next = S_IDLE;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_opcode    <= '0;
            r_len_lo    <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_tmo       <= '0;
            r_byte_idx  <= '0;
            r_first     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_rx_fire || !w_tmo_run) r_tmo <= '0;
            else                         r_tmo <= r_tmo + 32'd1;

            if (w_timeout) begin
                r_err       <= 1'b1;
                r_opcode    <= '0;
                r_hold_full <= 1'b0;
                r_cnt       <= '0;
                r_acc       <= '0;
                r_opnd      <= '0;
                r_byte_idx  <= '0;
            end else begin
                case (r_state)
                    S_IDLE:   if (w_rx_fire) r_opcode <= bus.rx_data_i;
                    S_LEN_LO: if (w_rx_fire) r_len_lo <= bus.rx_data_i;
                    S_LEN_HI: begin
                        if (w_rx_fire) begin
                            r_cnt       <= w_len - 16'd4;
                            r_byte_idx  <= '0;
                            r_first     <= 1'b1;
                            r_hold_full <= 1'b0;
                        end
                    end
                    S_ECHO: begin
                        if (w_rx_fire) begin
                            r_hold      <= bus.rx_data_i;
                            r_hold_full <= 1'b1;
                        end
                        if (w_tx_fire) begin
                            r_hold_full <= 1'b0;
                            r_cnt       <= r_cnt - 16'd1;
                        end
                    end
                    S_OPERAND: begin
                        if (w_rx_fire) begin
                            r_opnd     <= w_word;
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_cnt      <= r_cnt - 16'd1;
                            if (r_byte_idx == 2'd3 && r_first) begin
                                r_acc   <= w_word;
                                r_first <= 1'b0;
                            end
                        end
                    end
                    S_ALU_WAIT:  if (bus.alu_result_valid_i) r_acc <= bus.alu_result_i;
                    S_TX_RESULT: if (w_tx_fire) r_byte_idx <= r_byte_idx + 2'd1;
                    S_DRAIN:     if (w_rx_fire) r_cnt <= r_cnt - 16'd1;
                    S_TX_ERR:    if (w_tx_fire) r_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed plus randomized packet bench for alu_uart_ctrl with a behavioural
// packet-level reference model and a simple latency-configurable ALU.
module tb_alu_uart_ctrl;
    localparam int unsigned TMO = 50;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_uart_ctrl_if bus();

    alu_uart_ctrl #(.TIMEOUT_CYCLES(TMO), .ERR_BYTE(8'hEE)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    bq_t pkt, exp_q, txq;
    int  exp_err  = 0;
    int  err_cnt  = 0;
    int  stab_err = 0;
    logic [1:0]  req_op[$];
    logic [31:0] req_a[$], req_b[$];
    int  alu_rdy_dly = 0;
    int  alu_lat     = 1;
    bit  bp_rand     = 1'b0;
    logic tx_force   = 1'b1;
    logic [1:0]  m_op;
    logic [31:0] m_a, m_b, m_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a * b;
            default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    // Packet-level behaviour: what bytes come back, and how many error pulses.
    function automatic void model();
        int len, nops;
        logic [7:0]  op8;
        logic [1:0]  op;
        logic [31:0] acc, w;
        exp_q.delete();
        exp_err = 0;
        acc = '0;
        op8 = pkt[0];
        len = int'({pkt[3], pkt[2]});
        if (op8 == 8'hEC && len == 4) return;
        if (op8 == 8'hEC && len > 4) begin
            for (int i = 4; i < len; i++) exp_q.push_back(pkt[i]);
            return;
        end
        if ((op8 == 8'hAD || op8 == 8'h88 || op8 == 8'hD1) && len >= 8 && (len % 4) == 0) begin
            op   = (op8 == 8'hAD) ? 2'd0 : (op8 == 8'h88) ? 2'd1 : 2'd2;
            nops = (len - 4) / 4;
            for (int k = 0; k < nops; k++) begin
                w = {pkt[7 + 4*k], pkt[6 + 4*k], pkt[5 + 4*k], pkt[4 + 4*k]};
                acc = (k == 0) ? w : ref_alu(op, acc, w);
            end
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(acc >> (8*i)));
            return;
        end
        exp_q.push_back(8'hEE);
        exp_err = 1;
    endfunction

    function automatic void hdr(input logic [7:0] op, input logic [15:0] len);
        pkt.delete();
        pkt.push_back(op);
        pkt.push_back(8'($urandom));
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
    endfunction

    function automatic void push_w(input logic [31:0] w);
        for (int i = 0; i < 4; i++) pkt.push_back(8'(w >> (8*i)));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_valid_o && bus.tx_ready_i) txq.push_back(bus.tx_data_o);
            if (bus.error_o) err_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.tx_ready_i = bp_rand ? ($urandom_range(0, 1) != 0) : tx_force;
    end

    // ALU stand-in: delayed accept, fixed latency, watches request stability.
    always begin
        @(negedge clk);
        if (!rst && bus.alu_valid_o) begin
            m_op = bus.alu_op_o;
            m_a  = bus.alu_a_o;
            m_b  = bus.alu_b_o;
            req_op.push_back(m_op);
            req_a.push_back(m_a);
            req_b.push_back(m_b);
            for (int i = 0; i < alu_rdy_dly; i++) begin
                @(negedge clk);
                if (!bus.alu_valid_o || bus.alu_op_o !== m_op || bus.alu_a_o !== m_a || bus.alu_b_o !== m_b)
                    stab_err++;
            end
            bus.alu_ready_i = 1'b1;
            @(posedge clk);
            #1 bus.alu_ready_i = 1'b0;
            m_r = ref_alu(m_op, m_a, m_b);
            for (int i = 1; i < alu_lat; i++) begin
                @(posedge clk);
                #1;
            end
            bus.alu_result_i       = m_r;
            bus.alu_result_valid_i = 1'b1;
            @(posedge clk);
            #1 bus.alu_result_valid_i = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("rx_stall", 64'(n), 64'd0);
        @(posedge clk);
        #1 bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt(input int gmax);
        foreach (pkt[i]) begin
            send_byte(pkt[i]);
            repeat ($urandom_range(0, gmax)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_rsp(input int n);
        int c;
        c = 0;
        while (txq.size() < n && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 3000) chk("rsp_timeout", 64'(txq.size()), 64'(n));
        repeat (8) begin
            @(posedge clk);
            #1;
        end
    endtask

    // exp_q/exp_err must be set (constants or model) before calling.
    task automatic run_pkt(input string name, input int gmax);
        int e0;
        e0 = err_cnt;
        txq.delete();
        send_pkt(gmax);
        wait_rsp(exp_q.size());
        chk({name, "_count"}, 64'(txq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 64'(txq[i]), 64'(exp_q[i]));
        chk({name, "_err"}, 64'(err_cnt - e0), 64'(exp_err));
    endtask

    initial begin
        int e0, kind, nops, len;
        bit held_ok;
        logic [7:0] op8;

        bus.rx_data_i          = '0;
        bus.rx_valid_i         = 1'b0;
        bus.tx_ready_i         = 1'b1;
        bus.alu_ready_i        = 1'b0;
        bus.alu_result_i       = '0;
        bus.alu_result_valid_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", 64'(bus.rx_ready_o), 64'd0);
        chk("rst_tx_valid", 64'(bus.tx_valid_o), 64'd0);
        chk("rst_alu_valid", 64'(bus.alu_valid_o), 64'd0);
        chk("rst_error", 64'(bus.error_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rx_ready", 64'(bus.rx_ready_o), 64'd1);

        // Echo, tx always ready.
        hdr(8'hEC, 16'd7);
        pkt.push_back(8'h41); pkt.push_back(8'h42); pkt.push_back(8'h43);
        exp_q = '{8'h41, 8'h42, 8'h43};
        exp_err = 0;
        run_pkt("echo", 0);
        chk("echo_back_idle", 64'(bus.rx_ready_o), 64'd1);

        // ADD fold of three operands.
        req_op.delete(); req_a.delete(); req_b.delete();
        hdr(8'hAD, 16'h0010);
        push_w(32'd5); push_w(32'd7); push_w(32'd10);
        exp_q = '{8'h16, 8'h00, 8'h00, 8'h00};
        exp_err = 0;
        run_pkt("add", 0);
        chk("add_nreq", 64'(req_op.size()), 64'd2);
        if (req_op.size() == 2) begin
            chk("add_req0", {req_op[0], req_a[0], req_b[0][29:0]}, {2'd0, 32'd5, 30'd7});
            chk("add_req1", {req_op[1], req_a[1], req_b[1][29:0]}, {2'd0, 32'd12, 30'd10});
        end

        // MUL with slow ALU accept and latency.
        req_op.delete(); req_a.delete(); req_b.delete();
        alu_rdy_dly = 2; alu_lat = 3; stab_err = 0;
        hdr(8'h88, 16'h000C);
        push_w(32'hFFFF_FFFF); push_w(32'd2);
        exp_q = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
        exp_err = 0;
        run_pkt("mul", 0);
        chk("mul_stable", 64'(stab_err), 64'd0);
        chk("mul_nreq", 64'(req_op.size()), 64'd1);
        if (req_op.size() == 1)
            chk("mul_req", {req_op[0], req_a[0], req_b[0][29:0]}, {2'd1, 32'hFFFF_FFFF, 30'd2});
        alu_rdy_dly = 0; alu_lat = 1;

        // Malformed / unknown / boundary lengths.
        hdr(8'hAD, 16'h000A);
        for (int i = 0; i < 6; i++) pkt.push_back(8'(i + 1));
        exp_q = '{8'hEE}; exp_err = 1;
        run_pkt("bad_len", 0);
        hdr(8'h55, 16'h0006);
        pkt.push_back(8'h12); pkt.push_back(8'h34);
        exp_q = '{8'hEE}; exp_err = 1;
        run_pkt("bad_op", 0);
        hdr(8'hEC, 16'd4);
        exp_q.delete(); exp_err = 0;
        run_pkt("echo_len4", 0);
        hdr(8'hEC, 16'd3);
        exp_q = '{8'hEE}; exp_err = 1;
        run_pkt("echo_len3", 0);
        hdr(8'hAD, 16'd4);
        exp_q = '{8'hEE}; exp_err = 1;
        run_pkt("add_len4", 0);
        hdr(8'hD1, 16'd8);
        push_w(32'hCAFE_F00D);
        exp_q = '{8'h0D, 8'hF0, 8'hFE, 8'hCA}; exp_err = 0;
        run_pkt("single_op", 0);

        // Inactivity timeout inside an operand.
        e0 = err_cnt;
        txq.delete();
        hdr(8'hAD, 16'h000C);
        pkt.push_back(8'h01);
        send_pkt(0);
        repeat (45) begin @(posedge clk); #1; end
        chk("tmo_early", 64'(err_cnt - e0), 64'd0);
        repeat (15) begin @(posedge clk); #1; end
        chk("tmo_err", 64'(err_cnt - e0), 64'd1);
        chk("tmo_no_tx", 64'(txq.size()), 64'd0);
        hdr(8'hAD, 16'h000C);
        push_w(32'h1122_3344); push_w(32'h0101_0101);
        exp_q = '{8'h45, 8'h34, 8'h23, 8'h12}; exp_err = 0;
        run_pkt("after_tmo", 0);

        // Echo with transmitter stalled.
        txq.delete();
        tx_force = 1'b0;
        hdr(8'hEC, 16'd6);
        pkt.push_back(8'h41);
        send_pkt(0);
        held_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.rx_ready_o !== 1'b0 || bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h41) held_ok = 1'b0;
        end
        chk("bp_hold", 64'(held_ok), 64'd1);
        tx_force = 1'b1;
        pkt.delete();
        pkt.push_back(8'h42);
        send_pkt(0);
        wait_rsp(2);
        chk("bp_count", 64'(txq.size()), 64'd2);
        if (txq.size() == 2) chk("bp_bytes", {txq[0], txq[1]}, {8'h41, 8'h42});

        // Reset in the middle of an operand.
        hdr(8'hAD, 16'h000C);
        pkt.push_back(8'h77); pkt.push_back(8'h66);
        send_pkt(0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(bus.rx_ready_o), 64'd0);
        chk("mid_rst_a", 64'(bus.alu_a_o), 64'd0);
        chk("mid_rst_b", 64'(bus.alu_b_o), 64'd0);
        chk("mid_rst_tx", {bus.tx_valid_o, bus.tx_data_o, bus.alu_valid_o, bus.alu_op_o, bus.error_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        hdr(8'hAD, 16'h000C);
        push_w(32'd100); push_w(32'd23);
        exp_q = '{8'd123, 8'h00, 8'h00, 8'h00}; exp_err = 0;
        run_pkt("post_rst", 0);

        // Randomized packets against the packet-level model.
        bp_rand = 1'b1;
        for (int n = 0; n < 14; n++) begin
            alu_rdy_dly = $urandom_range(0, 3);
            alu_lat     = $urandom_range(1, 4);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                len = $urandom_range(5, 12);
                hdr(8'hEC, 16'(len));
                for (int i = 4; i < len; i++) pkt.push_back(8'($urandom));
            end else if (kind == 1) begin
                case ($urandom_range(0, 2))
                    0:       op8 = 8'hAD;
                    1:       op8 = 8'h88;
                    default: op8 = 8'hD1;
                endcase
                nops = $urandom_range(1, 4);
                hdr(op8, 16'(4 + 4*nops));
                for (int k = 0; k < nops; k++)
                    push_w((op8 == 8'hD1 && k > 0) ? 32'($urandom_range(0, 300)) : $urandom);
            end else begin
                if ($urandom_range(0, 1) == 0) begin
                    do op8 = 8'($urandom); while (op8 == 8'hEC || op8 == 8'hAD || op8 == 8'h88 || op8 == 8'hD1);
                    len = $urandom_range(5, 10);
                end else begin
                    op8 = 8'hAD;
                    len = 4 + 4*$urandom_range(0, 1) + $urandom_range(1, 3);
                end
                hdr(op8, 16'(len));
                for (int i = 4; i < len; i++) pkt.push_back(8'($urandom));
            end
            model();
            run_pkt($sformatf("rnd%0d", n), 3);
        end
        bp_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
